// File: rtl/alu_pkg.sv
// Op codes and widths shared by the ALU, the arbiter wrapper and the bench.
package alu_pkg;
    localparam int XLEN = 64;
    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_ADDW = 4'd10,
        ALU_SUBW = 4'd11,
        ALU_SLLW = 4'd12,
        ALU_SRLW = 4'd13,
        ALU_SRAW = 4'd14
    } alu_op_e;
endpackage

// File: rtl/alu.sv
// 64-bit integer ALU, purely combinational; W-ops work on the low word and sign-extend.
module alu
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [OP_W-1:0] i_op,
    output logic [XLEN-1:0] o_res
);
    logic [31:0] w_w32;

    always_comb begin
        w_w32 = '0;
        case (i_op)
            ALU_ADDW: w_w32 = i_a[31:0] + i_b[31:0];
            ALU_SUBW: w_w32 = i_a[31:0] - i_b[31:0];
            ALU_SLLW: w_w32 = i_a[31:0] << i_b[4:0];
            ALU_SRLW: w_w32 = i_a[31:0] >> i_b[4:0];
            ALU_SRAW: w_w32 = $signed(i_a[31:0]) >>> i_b[4:0];
            default:  w_w32 = '0;
        endcase
    end

    always_comb begin
        o_res = '0;
        case (i_op)
            ALU_ADD:  o_res = i_a + i_b;
            ALU_SUB:  o_res = i_a - i_b;
            ALU_AND:  o_res = i_a & i_b;
            ALU_OR:   o_res = i_a | i_b;
            ALU_XOR:  o_res = i_a ^ i_b;
            ALU_SLT:  o_res = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            ALU_SLTU: o_res = {{(XLEN-1){1'b0}}, i_a < i_b};
            ALU_SLL:  o_res = i_a << i_b[5:0];
            ALU_SRL:  o_res = i_a >> i_b[5:0];
            ALU_SRA:  o_res = $signed(i_a) >>> i_b[5:0];
            ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW:
                      o_res = {{32{w_w32[31]}}, w_w32};
            default:  o_res = '0;
        endcase
    end

    // The clock only qualifies this sanity check; the datapath has no state.
    a_op_known: assert property (@(posedge clk) !$isunknown(i_op));
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: search starts at i_ptr and wraps; first active request wins.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic             i_en,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx
);
    logic w_found;
    int   w_cand;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_cand    = 0;
        for (int k = 0; k < N; k++) begin
            w_cand = int'(i_ptr) + k;
            if (w_cand >= N) w_cand = w_cand - N;
            if (i_en && !w_found && i_req[w_cand]) begin
                o_gnt[w_cand] = 1'b1;
                o_gnt_idx     = IDX_W'(w_cand);
                w_found       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU among N_REQ requesters: RR grant -> operand reg (S1) -> result reg (S2).
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [XLEN*N_REQ-1:0] req_a,
    input  logic [XLEN*N_REQ-1:0] req_b,
    input  logic [OP_W*N_REQ-1:0] req_op,
    input  logic                  flush,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [XLEN-1:0]       rsp_res
);
    logic            r_s1_valid;
    logic [XLEN-1:0] r_s1_a;
    logic [XLEN-1:0] r_s1_b;
    logic [OP_W-1:0] r_s1_op;
    logic [ID_W-1:0] r_s1_id;
    logic            r_rsp_valid;
    logic [ID_W-1:0] r_rsp_id;
    logic [XLEN-1:0] r_rsp_res;
    logic [ID_W-1:0] r_rr_ptr;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_grant_en;
    logic [N_REQ-1:0] w_gnt;
    logic [ID_W-1:0]  w_gnt_idx;
    logic             w_accept;
    logic [ID_W-1:0]  w_ptr_next;
    logic [XLEN-1:0]  w_alu_res;

    assign w_s2_adv   = !r_rsp_valid || rsp_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_adv;
    // Reset gates the grant too, so nothing is accepted while rst is held.
    assign w_grant_en = !rst && !flush && (!r_s1_valid || w_s1_adv);
    assign w_accept   = |w_gnt;
    assign w_ptr_next = (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    rr_arbiter #(.N(N_REQ), .IDX_W(ID_W)) u_arb (
        .i_req     (req_valid),
        .i_ptr     (r_rr_ptr),
        .i_en      (w_grant_en),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    alu u_alu (
        .clk   (clk),
        .i_a   (r_s1_a),
        .i_b   (r_s1_b),
        .i_op  (r_s1_op),
        .o_res (w_alu_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_op     <= '0;
            r_s1_id     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_res   <= '0;
            r_rr_ptr    <= '0;
        end else if (flush) begin
            r_s1_valid  <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                r_rsp_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_rsp_res <= w_alu_res;
                    r_rsp_id  <= r_s1_id;
                end
            end
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_a     <= req_a[XLEN*w_gnt_idx +: XLEN];
                r_s1_b     <= req_b[XLEN*w_gnt_idx +: XLEN];
                r_s1_op    <= req_op[OP_W*w_gnt_idx +: OP_W];
                r_s1_id    <= w_gnt_idx;
                r_rr_ptr   <= w_ptr_next;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    assign req_ready = w_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_res   = r_rsp_res;
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: latency, fairness, ALU ops, backpressure, flush, reset.
module tb_alu_share_arb;
    import alu_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [7:0]   req_op;
    logic         flush;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [0:0]   rsp_id;
    logic [63:0]  rsp_res;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.N_REQ(2), .ID_W(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res)
    );

    localparam int NV = 13;
    logic [63:0] v_a   [NV] = '{64'h7FFF_FFFF, 64'h8000_0000, 64'h1, 64'h3,
                                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                                64'h0, 64'hFFFF_FFFF_8000_0000, 64'h1, 64'hF0F0, 64'h5};
    logic [63:0] v_b   [NV] = '{64'h1, 64'h24, 64'h43, 64'h5, 64'h1, 64'h1, 64'h4,
                                64'h44, 64'h1, 64'h21, 64'h1F, 64'hFF00, 64'h5};
    logic [3:0]  v_op  [NV] = '{ALU_ADDW, ALU_SRAW, ALU_SLL, ALU_SUB, ALU_SLT, ALU_SLTU,
                                ALU_SRA, ALU_SRL, ALU_SUBW, ALU_SRLW, ALU_SLLW, ALU_XOR,
                                4'hF};
    logic [63:0] v_exp [NV] = '{64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_F800_0000, 64'h8,
                                64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 64'h0,
                                64'hF800_0000_0000_0000, 64'h0800_0000_0000_0000,
                                64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_4000_0000,
                                64'hFFFF_FFFF_8000_0000, 64'h0FF0, 64'h0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                           input logic [3:0] op);
        req_a[64*i +: 64] = a;
        req_b[64*i +: 64] = b;
        req_op[4*i +: 4]  = op;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        flush     = 1'b0;
        rsp_ready = 1'b1;

        tick();
        tick();
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_id",    64'(rsp_id),    64'd0);
        check("rst_rsp_res",   rsp_res,        64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);

        // single op
        tick();
        rst = 1'b0;
        req_valid = 2'b01;
        set_req(0, 64'd3, 64'd5, ALU_ADD);
        #1;
        check("single_ready", 64'(req_ready), 64'b01);
        tick();
        req_valid = 2'b00;
        #1;
        check("single_lat1_valid", 64'(rsp_valid), 64'd0);
        tick();
        #1;
        check("single_valid", 64'(rsp_valid), 64'd1);
        check("single_res",   rsp_res,        64'd8);
        check("single_id",    64'(rsp_id),    64'd0);
        tick();
        #1;
        check("single_done", 64'(rsp_valid), 64'd0);

        // fairness: pointer sits at 1 after the single op from requester 0
        set_req(0, 64'd100, 64'd1, ALU_ADD);
        set_req(1, 64'd200, 64'd2, ALU_SUB);
        for (int t = 0; t < 9; t++) begin
            tick();
            req_valid = (t < 6) ? 2'b11 : 2'b00;
            #1;
            if (t < 6) check("fair_gnt", 64'(req_ready), (t % 2 == 0) ? 64'b10 : 64'b01);
            if (t >= 2 && t < 8) begin
                check("fair_valid", 64'(rsp_valid), 64'd1);
                check("fair_id",    64'(rsp_id),    (t % 2 == 0) ? 64'd1 : 64'd0);
                check("fair_res",   rsp_res,        (t % 2 == 0) ? 64'd198 : 64'd101);
            end else begin
                check("fair_idle", 64'(rsp_valid), 64'd0);
            end
        end

        // ALU op table streamed from requester 0
        for (int t = 0; t < NV + 2; t++) begin
            tick();
            if (t < NV) begin
                req_valid = 2'b01;
                set_req(0, v_a[t], v_b[t], v_op[t]);
            end else begin
                req_valid = 2'b00;
            end
            #1;
            if (t < NV) check("op_ready", 64'(req_ready), 64'b01);
            if (t >= 2) begin
                check("op_valid", 64'(rsp_valid), 64'd1);
                check("op_res",   rsp_res,        v_exp[t-2]);
                check("op_id",    64'(rsp_id),    64'd0);
            end else begin
                check("op_fill", 64'(rsp_valid), 64'd0);
            end
        end
        tick();
        #1;
        check("op_drain", 64'(rsp_valid), 64'd0);

        // backpressure with requester 1 streaming
        tick();
        rsp_ready = 1'b0;
        req_valid = 2'b10;
        set_req(1, 64'd1000, 64'd1, ALU_ADD);
        #1;
        check("bp_ready0", 64'(req_ready), 64'b10);
        tick();
        set_req(1, 64'd2000, 64'd2, ALU_ADD);
        #1;
        check("bp_ready1", 64'(req_ready), 64'b10);
        check("bp_valid1", 64'(rsp_valid), 64'd0);
        tick();
        set_req(1, 64'd3000, 64'd3, ALU_ADD);
        #1;
        check("bp_ready2", 64'(req_ready), 64'b00);
        check("bp_valid2", 64'(rsp_valid), 64'd1);
        check("bp_res2",   rsp_res,        64'd1001);
        check("bp_id2",    64'(rsp_id),    64'd1);
        tick();
        #1;
        check("bp_ready3", 64'(req_ready), 64'b00);
        check("bp_res3",   rsp_res,        64'd1001);
        tick();
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        #1;
        check("bp_valid4", 64'(rsp_valid), 64'd1);
        check("bp_res4",   rsp_res,        64'd1001);
        tick();
        #1;
        check("bp_valid5", 64'(rsp_valid), 64'd1);
        check("bp_res5",   rsp_res,        64'd2002);
        check("bp_id5",    64'(rsp_id),    64'd1);
        tick();
        #1;
        check("bp_done", 64'(rsp_valid), 64'd0);

        // flush with two ops in flight; pointer is 0 here
        tick();
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        set_req(0, 64'd7, 64'd1, ALU_ADD);
        #1;
        check("fl_ready0", 64'(req_ready), 64'b01);
        tick();
        set_req(0, 64'd9, 64'd1, ALU_ADD);
        #1;
        check("fl_ready1", 64'(req_ready), 64'b01);
        tick();
        flush = 1'b1;
        rsp_ready = 1'b1;
        #1;
        check("fl_ready_flush", 64'(req_ready), 64'b00);
        check("fl_valid_flush", 64'(rsp_valid), 64'd1);
        check("fl_res_flush",   rsp_res,        64'd8);
        tick();
        flush = 1'b0;
        req_valid = 2'b11;
        set_req(1, 64'd40, 64'd2, ALU_ADD);
        #1;
        check("fl_killed", 64'(rsp_valid), 64'd0);
        check("fl_ptr",    64'(req_ready), 64'b10);
        tick();
        req_valid = 2'b00;
        #1;
        check("fl_s1_kill", 64'(rsp_valid), 64'd0);
        tick();
        #1;
        check("fl_after_valid", 64'(rsp_valid), 64'd1);
        check("fl_after_id",    64'(rsp_id),    64'd1);
        check("fl_after_res",   rsp_res,        64'd42);
        tick();
        #1;
        check("fl_done", 64'(rsp_valid), 64'd0);

        // reset with a full pipeline; pointer ends at 1 before reset
        tick();
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        set_req(0, 64'd7, 64'd1, ALU_ADD);
        #1;
        check("rs_ready0", 64'(req_ready), 64'b01);
        tick();
        #1;
        check("rs_ready1", 64'(req_ready), 64'b01);
        tick();
        #1;
        check("rs_full", 64'(rsp_valid), 64'd1);
        tick();
        rst = 1'b1;
        req_valid = 2'b11;
        #1;
        check("rs_ready_in_rst", 64'(req_ready), 64'b00);
        tick();
        #1;
        check("rs_valid_after", 64'(rsp_valid), 64'd0);
        check("rs_ready_after", 64'(req_ready), 64'b00);
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("rs_first_gnt", 64'(req_ready), 64'b01);
        tick();
        #1;
        check("rs_second_gnt", 64'(req_ready), 64'b10);
        tick();
        req_valid = 2'b00;
        #1;
        check("rs_rsp0_id",  64'(rsp_id), 64'd0);
        check("rs_rsp0_res", rsp_res,     64'd8);
        tick();
        #1;
        check("rs_rsp1_valid", 64'(rsp_valid), 64'd1);
        check("rs_rsp1_id",    64'(rsp_id),    64'd1);
        check("rs_rsp1_res",   rsp_res,        64'd42);
        tick();
        #1;
        check("rs_done", 64'(rsp_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
